fixed_to_bcd: RTL and testbench

FIXED_TO_BCD -- requirements
Module: fixed_to_bcd

---
 rtl/fixed_to_bcd.sv | 200 ++++++++++++++++++++
 tb/tb_fixed_to_bcd.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fixed_to_bcd.sv
// Purpose : converts a signed Q16.16 value to sign + 5 BCD integer digits + FRAC_DIGITS BCD fraction digits.
// Latency : accepting edge, then 16 INT cycles and FRAC_DIGITS FRAC cycles; done pulses in the following DONE cycle.
// Backpr. : no stall input; start is taken only while busy=0 (IDLE or DONE) and is ignored while busy=1.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, value        conversion request and its Q16.16 two's-complement operand
//   overflow_in         ALU overflow flag travelling with value, reported back on ovf
//   busy, done          conversion in flight / one-cycle result-valid pulse
//   sign, int_bcd,      registered result: sign, 5 integer BCD digits (MSD at [19:16]),
//   frac_bcd, ovf       fraction digits (first digit at [15:12]) and latched overflow flag
module fixed_to_bcd #(
  parameter int FRAC_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        overflow_in,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [19:0] int_bcd,
  output logic [15:0] frac_bcd,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INT  = 2'd1,
    FRAC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] INT_LAST  = 5'd15;
  localparam logic [4:0] FRAC_LAST = 5'(FRAC_DIGITS - 1);

  state_t      state;
  state_t      state_nxt;

  logic        accept;
  logic [4:0]  cnt;

  // working registers of the conversion in flight
  logic        sign_work;
  logic        ovf_work;
  logic [15:0] int_shift;
  logic [19:0] bcd_work;
  logic [15:0] frac_rem;
  logic [15:0] frac_digits;

  // combinational helpers
  logic [31:0] mag;
  logic [19:0] bcd_adj;
  logic [19:0] product;
  logic [3:0]  frac_digit;
  logic [15:0] frac_next;

  // A new request is taken in IDLE and also in the DONE cycle, so a held
  // start produces back-to-back conversions without an idle gap.
  assign accept = start && ((state == IDLE) || (state == DONE));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = INT;
      end
      INT: begin
        if (cnt == INT_LAST) state_nxt = FRAC;
      end
      FRAC: begin
        if (cnt == FRAC_LAST) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = start ? INT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      INT:     busy = 1'b1;
      FRAC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath combinational helpers
  // ---------------------------------------------------------------------

  // Two's-complement magnitude; 0x8000_0000 negates onto itself, which read
  // as unsigned is exactly the 32768.0 magnitude wanted.
  always_comb begin
    mag = value;
    if (value[31]) mag = ~value + 32'd1;
  end

  // Double-dabble correction: any digit >= 5 gets +3 so that the following
  // left shift carries correctly into the next decimal digit.
  always_comb begin
    bcd_adj = bcd_work;
    for (int d = 0; d < 5; d++) begin
      if (bcd_work[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd_work[d*4 +: 4] + 4'd3;
      end
    end
  end

  // One decimal fraction digit per cycle: multiply the remaining binary
  // fraction by ten, the overflow above bit 15 is the next digit (truncating).
  always_comb begin
    product    = {4'd0, frac_rem} * 20'd10;
    frac_digit = product[19:16];
    frac_next  = frac_digits;
    case (cnt[1:0])
      2'd0:    frac_next[15:12] = frac_digit;
      2'd1:    frac_next[11:8]  = frac_digit;
      2'd2:    frac_next[7:4]   = frac_digit;
      default: frac_next[3:0]   = frac_digit;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers and result outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 5'd0;
      sign_work   <= 1'b0;
      ovf_work    <= 1'b0;
      int_shift   <= 16'd0;
      bcd_work    <= 20'd0;
      frac_rem    <= 16'd0;
      frac_digits <= 16'd0;
      sign        <= 1'b0;
      int_bcd     <= 20'd0;
      frac_bcd    <= 16'd0;
      ovf         <= 1'b0;
    end else if (accept) begin
      cnt         <= 5'd0;
      sign_work   <= value[31];
      ovf_work    <= overflow_in;
      int_shift   <= mag[31:16];
      bcd_work    <= 20'd0;
      frac_rem    <= mag[15:0];
      frac_digits <= 16'd0;
    end else begin
      case (state)
        INT: begin
          // integer bits enter the BCD register MSB first
          bcd_work  <= {bcd_adj[18:0], int_shift[15]};
          int_shift <= {int_shift[14:0], 1'b0};
          cnt       <= (cnt == INT_LAST) ? 5'd0 : cnt + 5'd1;
        end
        FRAC: begin
          frac_rem    <= product[15:0];
          frac_digits <= frac_next;
          cnt         <= cnt + 5'd1;
          if (cnt == FRAC_LAST) begin
            // results only move on the edge that enters DONE
            sign     <= sign_work;
            int_bcd  <= bcd_work;
            frac_bcd <= frac_next;
            ovf      <= ovf_work;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_bcd.sv
// Directed bench for fixed_to_bcd: hand-computed vectors, latency, hold,
// ignored start while busy, back-to-back and reset abort.
module tb_fixed_to_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        overflow_in;
  logic        busy;
  logic        done;
  logic        sign;
  logic [19:0] int_bcd;
  logic [15:0] frac_bcd;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fixed_to_bcd #(.FRAC_DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .value       (value),
    .overflow_in (overflow_in),
    .busy        (busy),
    .done        (done),
    .sign        (sign),
    .int_bcd     (int_bcd),
    .frac_bcd    (frac_bcd),
    .ovf         (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after the accepting edge. Cycle n is the n-th cycle after
  // that edge, sampled on the falling edge. Returns the cycle in which done
  // was seen (-1 if never). start is driven each cycle: held high, or a
  // one-cycle pulse in cycle pulse_cyc carrying pulse_val.
  task automatic wait_done(input int pulse_cyc, input logic [31:0] pulse_val,
                           input bit hold, input logic [19:0] prev_int,
                           output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (n == 1)  check("busy_after_accept", 32'(busy), 32'd1);
      if (n == 10) check("int_hold_mid_conv", 32'(int_bcd), 32'(prev_int));
      start = hold || (n == pulse_cyc);
      if (n == pulse_cyc) value = pulse_val;
    end
  endtask

  task automatic check_result(input string name, input int lat,
                              input logic exp_sign, input logic [19:0] exp_int,
                              input logic [15:0] exp_frac, input logic exp_ovf);
    check($sformatf("%s.latency", name), 32'(lat), 32'd21);
    check($sformatf("%s.busy_in_done", name), 32'(busy), 32'd0);
    check($sformatf("%s.sign", name), 32'(sign), 32'(exp_sign));
    check($sformatf("%s.int_bcd", name), 32'(int_bcd), 32'(exp_int));
    check($sformatf("%s.frac_bcd", name), 32'(frac_bcd), 32'(exp_frac));
    check($sformatf("%s.ovf", name), 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic convert(input string name, input logic [31:0] v, input logic ovfi,
                         input logic [19:0] prev_int, input logic exp_sign,
                         input logic [19:0] exp_int, input logic [15:0] exp_frac,
                         input logic exp_ovf);
    int lat;
    @(negedge clk);
    value       = v;
    overflow_in = ovfi;
    start       = 1'b1;
    wait_done(0, 32'h0, 1'b0, prev_int, lat);
    check_result(name, lat, exp_sign, exp_int, exp_frac, exp_ovf);
    @(negedge clk);
    check($sformatf("%s.done_one_cycle", name), 32'(done), 32'd0);
    check($sformatf("%s.idle_after", name), 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int seen_done;

    rst         = 1'b1;
    start       = 1'b0;
    value       = 32'h0;
    overflow_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.sign", 32'(sign), 32'd0);
    check("rst.int_bcd", 32'(int_bcd), 32'd0);
    check("rst.frac_bcd", 32'(frac_bcd), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    //       name      value          ovf   prev      sign  int        frac      ovf
    convert("p1_5",   32'h0001_8000, 1'b0, 20'h0,     1'b0, 20'h00001, 16'h5000, 1'b0);
    convert("m1_0",   32'hFFFF_0000, 1'b1, 20'h1,     1'b1, 20'h00001, 16'h0000, 1'b1);
    convert("min",    32'h8000_0000, 1'b0, 20'h1,     1'b1, 20'h32768, 16'h0000, 1'b0);
    convert("max",    32'h7FFF_FFFF, 1'b0, 20'h32768, 1'b0, 20'h32767, 16'h9999, 1'b0);
    convert("lsb",    32'h0000_0001, 1'b0, 20'h32767, 1'b0, 20'h00000, 16'h0000, 1'b0);
    convert("zero",   32'h0000_0000, 1'b0, 20'h0,     1'b0, 20'h00000, 16'h0000, 1'b0);

    // start while busy is ignored; start in the DONE cycle is accepted
    @(negedge clk);
    value = 32'h0001_8000;
    start = 1'b1;
    wait_done(5, 32'h0002_0000, 1'b0, 20'h0, lat);
    check_result("ign", lat, 1'b0, 20'h00001, 16'h5000, 1'b0);
    start = 1'b1;
    value = 32'h0002_0000;
    wait_done(0, 32'h0, 1'b0, 20'h1, lat);
    check_result("in_done", lat, 1'b0, 20'h00002, 16'h0000, 1'b0);
    @(negedge clk);
    check("in_done.done_one_cycle", 32'(done), 32'd0);

    // reset in the middle of INT aborts the conversion
    @(negedge clk);
    value = 32'h0005_0000;
    start = 1'b1;
    @(negedge clk);              // cycle 1
    start = 1'b0;
    repeat (9) @(negedge clk);   // cycle 10
    rst = 1'b1;
    @(negedge clk);              // cycle 11
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.int_bcd", 32'(int_bcd), 32'd0);
    check("abort.frac_bcd", 32'(frac_bcd), 32'd0);
    check("abort.sign_ovf", {30'd0, sign, ovf}, 32'd0);
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort.no_done", 32'(seen_done), 32'd0);
    convert("post_rst", 32'h0003_4000, 1'b0, 20'h0, 1'b0, 20'h00003, 16'h2500, 1'b0);

    // continuous start: back-to-back conversions, each accepted in DONE
    @(negedge clk);
    value = 32'h0000_C000;
    start = 1'b1;
    wait_done(0, 32'h0, 1'b1, 20'h3, lat);
    check_result("b2b_first", lat, 1'b0, 20'h00000, 16'h7500, 1'b0);
    wait_done(0, 32'h0, 1'b1, 20'h0, lat);
    check_result("b2b_second", lat, 1'b0, 20'h00000, 16'h7500, 1'b0);
    start = 1'b0;
    @(negedge clk);
    check("b2b.stop_busy", 32'(busy), 32'd0);
    check("b2b.stop_done", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
